// File: rtl/logic_op_pipe.sv
// logic_op_pipe: elastic AND/OR/XOR/NAND unit with comb and pipelined results.
// Define LOGIC_OP_PIPE_CNT_EN to build the saturating xfer_cnt counter.
module logic_op_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic [WIDTH-1:0] comb_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_in_v;
  logic [WIDTH-1:0]  w_in_d [STAGES];

  always_comb begin
    comb_y = '0;
    unique case (in_op)
      2'b00: comb_y = in_a & in_b;
      2'b01: comb_y = in_a | in_b;
      2'b10: comb_y = in_a ^ in_b;
      2'b11: comb_y = ~(in_a & in_b);
    endcase
  end

  // A stage is ready if it or any stage downstream is empty, or the sink takes.
  always_comb begin : ready_chain
    logic w_acc;
    w_acc = out_ready;
    w_rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_acc    = w_acc | ~r_vld[k];
      w_rdy[k] = w_acc;
    end
  end

  always_comb begin
    w_in_v    = '0;
    w_in_v[0] = in_valid;
    w_in_d[0] = comb_y;
    for (int k = 1; k < STAGES; k++) begin
      w_in_v[k] = r_vld[k-1];
      w_in_d[k] = r_data[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < STAGES; k++)
        r_data[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= w_in_v[k];
          if (w_in_v[k])
            r_data[k] <= w_in_d[k];
        end
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld[STAGES-1];
  assign out_y     = r_data[STAGES-1];
  assign out_zero  = out_valid && (out_y == '0);

`ifdef LOGIC_OP_PIPE_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_xfer;

  assign w_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_xfer && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign xfer_cnt = r_cnt;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed self-checking bench for logic_op_pipe (STAGES=2).
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_logic_op_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic [7:0] comb_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;
  logic [15:0] xfer_cnt;

  logic       s_in_ready;
  logic [7:0] s_comb_y;
  logic       s_out_valid;
  logic [7:0] s_out_y;
  logic       s_out_zero;
  logic [1:0] s_xfer_cnt;

  int n_cmp;
  int n_bad;
  int n_xfer;

  logic [7:0] exp_y [4];

  logic_op_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .comb_y(comb_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero),
    .xfer_cnt(xfer_cnt)
  );

  logic_op_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .comb_y(s_comb_y),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_y(s_out_y), .out_zero(s_out_zero),
    .xfer_cnt(s_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] cnt_main(int n);
`ifdef LOGIC_OP_PIPE_CNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [1:0] cnt_small(int n);
`ifdef LOGIC_OP_PIPE_CNT_EN
    return (n > 3) ? 2'd3 : 2'(n);
`else
    return 2'd0;
`endif
  endfunction

  task automatic test_reset();
    logic [7:0] e [4];
    e[0] = 8'h30; e[1] = 8'hFC; e[2] = 8'hCC; e[3] = 8'hCF;
    rst_n = 1'b0;
    in_a = 8'hF0;
    in_b = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      in_op = 2'(i);
      #2;
      n_cmp++;
      if (comb_y !== e[i]) begin
        n_bad++;
        $display("FAIL reset_comb op=%0d got %h want %h", i, comb_y, e[i]);
      end
      n_cmp++;
      if ({out_valid, out_y, out_zero, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL reset_state got v=%b y=%h z=%b rdy=%b want 0 00 0 1",
                 out_valid, out_y, out_zero, in_ready);
      end
      n_cmp++;
      if (xfer_cnt !== 16'd0) begin
        n_bad++;
        $display("FAIL reset_cnt got %0d want 0", xfer_cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_xfer = 0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    exp_y[0] = 8'h05; exp_y[1] = 8'hAF; exp_y[2] = 8'hAA; exp_y[3] = 8'hFA;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h0F; in_op = 2'(i);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_y !== exp_y[i-1]) begin
          n_bad++;
          $display("FAIL stream_out%0d got v=%b y=%h want 1 %h",
                   i - 1, out_valid, out_y, exp_y[i-1]);
        end
        n_xfer++;
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_empty got v=%b want 0", out_valid);
    end
    n_cmp++;
    if (xfer_cnt !== cnt_main(n_xfer)) begin
      n_bad++;
      $display("FAIL stream_cnt got %0d want %0d", xfer_cnt, cnt_main(n_xfer));
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h0F; in_op = 2'd0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_rdy0 got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_op = 2'd1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_rdy1 got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_op = 2'd2;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h05) begin
      n_bad++;
      $display("FAIL bp_full got rdy=%b v=%b y=%h want 0 1 05",
               in_ready, out_valid, out_y);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h05) begin
      n_bad++;
      $display("FAIL bp_hold got rdy=%b v=%b y=%h want 0 1 05",
               in_ready, out_valid, out_y);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_rdy got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    n_xfer++;
    in_valid = 1'b0;
    in_op = 2'd3;
    in_a = 8'h00;
    n_cmp++;
    if (out_valid !== 1'b1 || out_y !== 8'hAF) begin
      n_bad++;
      $display("FAIL bp_drain1 got v=%b y=%h want 1 AF", out_valid, out_y);
    end
    @(posedge clk); #1;
    n_xfer++;
    n_cmp++;
    if (out_valid !== 1'b1 || out_y !== 8'hAA) begin
      n_bad++;
      $display("FAIL bp_drain2 got v=%b y=%h want 1 AA", out_valid, out_y);
    end
    @(posedge clk); #1;
    n_xfer++;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_empty got v=%b want 0", out_valid);
    end
    n_cmp++;
    if (xfer_cnt !== cnt_main(n_xfer)) begin
      n_bad++;
      $display("FAIL bp_cnt got %0d want %0d", xfer_cnt, cnt_main(n_xfer));
    end
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h55; in_b = 8'hAA; in_op = 2'd0;
    @(posedge clk); #1;
    in_op = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_y !== 8'h00 || out_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_and got v=%b y=%h z=%b want 1 00 1",
               out_valid, out_y, out_zero);
    end
    @(posedge clk); #1;
    n_xfer++;
    n_cmp++;
    if (out_valid !== 1'b1 || out_y !== 8'hFF || out_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_xor got v=%b y=%h z=%b want 1 FF 0",
               out_valid, out_y, out_zero);
    end
    @(posedge clk); #1;
    n_xfer++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h0F; in_op = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_loaded got v=%b want 1", out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || in_ready !== 1'b1
        || xfer_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_async got v=%b y=%h rdy=%b cnt=%0d want 0 00 1 0",
               out_valid, out_y, in_ready, xfer_cnt);
    end
    #1;
    rst_n = 1'b1;
    n_xfer = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_ghost%0d got v=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h55; in_b = 8'hAA; in_op = 2'd1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_xfer += 5;
    n_cmp++;
    if (s_xfer_cnt !== cnt_small(n_xfer)) begin
      n_bad++;
      $display("FAIL sat_small got %0d want %0d", s_xfer_cnt, cnt_small(n_xfer));
    end
    n_cmp++;
    if (xfer_cnt !== cnt_main(n_xfer)) begin
      n_bad++;
      $display("FAIL sat_main got %0d want %0d", xfer_cnt, cnt_main(n_xfer));
    end
    n_cmp++;
    if (s_out_y !== 8'hFF || s_out_zero !== 1'b0 || s_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_outs got y=%h z=%b v=%b want FF 0 0",
               s_out_y, s_out_zero, s_out_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_xfer = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
